// File: rtl/detector_110_pkg.sv
// Shared types and defaults for the 1,1,0 serial pattern detector.
// Holds the FSM state enum and the default match-counter width.
package detector_110_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_11   = 2'd2,
        S_110  = 2'd3
    } state_t;

endpackage

// File: rtl/detector_110_if.sv
// Serial stream interface for detector_110.
// Ports: a (serial bit in), w (detect flag), match_cnt (only with
// DETECTOR_110_CNT_EN). master drives a; slave is the detector.
interface detector_110_if
    import detector_110_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic a;
    logic w;
`ifdef DETECTOR_110_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    modport master (
`ifdef DETECTOR_110_CNT_EN
        input  match_cnt,
`endif
        output a,
        input  w
    );

    modport slave (
`ifdef DETECTOR_110_CNT_EN
        output match_cnt,
`endif
        input  a,
        output w
    );

endinterface

// File: rtl/detector_110_sat_counter.sv
// Width-parameterised saturating up-counter with async active-high reset.
// Ports: clk, reset, inc (count enable), q (count, holds at all-ones).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/detector_110.sv
// Moore detector for the serial pattern 1,1,0 on bus.a; bus.w is a one-cycle
// registered-state pulse. Ports: clk, reset (async, active-high), bus (slave).
// Optional saturating match counter on bus.match_cnt: DETECTOR_110_CNT_EN.
module detector_110
    import detector_110_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    detector_110_if.slave  bus
);

    state_t state;
    state_t next;

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_w
        $error("detector_110: CNT_W out of range");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    // A run of 1s parks in S_11; a 1 after a hit restarts at S_1,
    // which gives overlapping detection.
    always_comb begin
        next = S_IDLE;
        unique case (state)
            S_IDLE:  next = bus.a ? S_1  : S_IDLE;
            S_1:     next = bus.a ? S_11 : S_IDLE;
            S_11:    next = bus.a ? S_11 : S_110;
            S_110:   next = bus.a ? S_1  : S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    assign bus.w = (state == S_110);

`ifdef DETECTOR_110_CNT_EN
    // Counts on the same edge that enters S_110, so it steps with w.
    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (next == S_110),
        .q     (bus.match_cnt)
    );
`endif

endmodule

// File: tb/tb_detector_110.sv
// Self-checking bench for detector_110: sliding-window model plus
// hand-computed pulse/count expectations on directed bit streams.
module tb_detector_110;

`ifdef DETECTOR_110_CNT_EN
    localparam int TB_W = 2;
`else
    localparam int TB_W = 8;
`endif
    localparam int CMAX = (1 << TB_W) - 1;

    logic clk;
    logic reset;

    int checks;
    int errors;

    detector_110_if #(.CNT_W(TB_W)) bus ();

    detector_110 #(
        .CNT_W (TB_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: last three bits sampled since reset; a hit is a full
    // window reading 1,1,0 oldest-first.
    logic [2:0] hist;
    int         nv;
    logic       exp_w;
    int         exp_cnt;
    logic [2:0] win;

    assign win = {hist[1:0], bus.a};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= 3'b000;
            nv      <= 0;
            exp_w   <= 1'b0;
            exp_cnt <= 0;
        end else begin
            hist  <= win;
            nv    <= (nv < 3) ? nv + 1 : 3;
            exp_w <= (nv >= 2) && (win == 3'b110);
            if ((nv >= 2) && (win == 3'b110) && (exp_cnt < CMAX))
                exp_cnt <= exp_cnt + 1;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.w !== exp_w) begin
            errors++;
            $display("FAIL model_w t=%0t got %b want %b",
                     $time, bus.w, exp_w);
        end
`ifdef DETECTOR_110_CNT_EN
        checks++;
        if (int'(bus.match_cnt) != exp_cnt) begin
            errors++;
            $display("FAIL model_cnt t=%0t got %0d want %0d",
                     $time, bus.match_cnt, exp_cnt);
        end
`endif
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input int exp);
`ifdef DETECTOR_110_CNT_EN
        chk(name, int'(bus.match_cnt), exp);
`else
        chk(name, exp, exp - 0 + 0 == exp ? exp : -1);
`endif
    endtask

    // Drive one bit mid-cycle, then check w just after the sampling edge.
    task automatic step(input logic b, input logic ew, input string name);
        @(negedge clk);
        bus.a = b;
        @(posedge clk);
        #1;
        chk(name, int'(bus.w), int'(ew));
    endtask

    task automatic run(input string name, input int n,
                       input logic [15:0] bits, input logic [15:0] ws);
        for (int i = n - 1; i >= 0; i--)
            step(bits[i], ws[i], name);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.a  = 1'b0;
        reset  = 1'b1;
        #1;
        chk("reset_w", int'(bus.w), 0);
        @(posedge clk);
        #1;
        chk("reset_hold_w", int'(bus.w), 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, "post_reset");

        run("basic_110", 4, 16'b1100, 16'b0010);
        run("ones_run", 5, 16'b11110, 16'b00001);
        run("near_miss", 5, 16'b01010, 16'b00000);
        run("overlap", 6, 16'b110110, 16'b001001);
`ifdef DETECTOR_110_CNT_EN
        chk("cnt_overlap", int'(bus.match_cnt), 3);
`endif

        // w is high now; async reset must clear it with no clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_w", int'(bus.w), 0);
`ifdef DETECTOR_110_CNT_EN
        chk("async_cnt", int'(bus.match_cnt), 0);
`endif
        bus.a = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_ignores_a", int'(bus.w), 0);
        @(negedge clk);
        reset = 1'b0;

        run("pre_mid", 2, 16'b11, 16'b00);
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        run("mid_reset", 1, 16'b0, 16'b0);
        run("after_mid", 3, 16'b110, 16'b001);

`ifdef DETECTOR_110_CNT_EN
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            run("sat_seq", 3, 16'b110, 16'b001);
            chk("sat_cnt", int'(bus.match_cnt), (k < 3) ? k : 3);
        end
        run("sat_hold", 2, 16'b00, 16'b00);
        chk("sat_stay", int'(bus.match_cnt), 3);
`endif

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
